order_failure_tracker: RTL and testbench

ORDER_FAILURE_TRACKER -- requirements
Module: order_failure_tracker

---
 rtl/order_failure_tracker_if.sv | 43 ++++
 rtl/order_failure_tracker.sv | 82 ++++++++
 tb/tb_order_failure_tracker.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/order_failure_tracker_if.sv
// order_failure_tracker_if: load/store queue snapshot, store commits and flush handshake for order_failure_tracker
//   master: ldq_* / stq_* queue state, stq_commit*, flush_ready (driven); flush_valid, flush_ldq_index,
//           pending_failures, failure_count (observed)
//   slave : the reverse directions, used by the tracker
interface order_failure_tracker_if #(
  parameter int XLEN = 32,
  parameter int LDQ_SIZE = 32,
  parameter int STQ_SIZE = 32,
  parameter int COMMIT_WIDTH = 2
);
  localparam int LW = $clog2(LDQ_SIZE);
  localparam int SW = $clog2(STQ_SIZE);
  logic [LDQ_SIZE-1:0] ldq_valid;
  logic [LDQ_SIZE-1:0] ldq_succeeded;
  logic [LDQ_SIZE-1:0] ldq_forward_stq_data;
  logic [LDQ_SIZE-1:0][XLEN-1:0] ldq_address;
  logic [LDQ_SIZE-1:0][3:0] ldq_byte_mask;
  logic [LDQ_SIZE-1:0][STQ_SIZE-1:0] ldq_store_mask;
  logic [LDQ_SIZE-1:0][SW-1:0] ldq_forward_stq_index;
  logic [LW-1:0] ldq_head;
  logic [SW-1:0] stq_head;
  logic [STQ_SIZE-1:0][XLEN-1:0] stq_address;
  logic [STQ_SIZE-1:0][3:0] stq_byte_mask;
  logic [COMMIT_WIDTH-1:0] stq_commit;
  logic [COMMIT_WIDTH-1:0][SW-1:0] stq_commit_index;
  logic flush_valid;
  logic [LW-1:0] flush_ldq_index;
  logic flush_ready;
  logic [LDQ_SIZE-1:0] pending_failures;
  logic [15:0] failure_count;
  modport master (
    output ldq_valid, ldq_succeeded, ldq_forward_stq_data, ldq_address, ldq_byte_mask, ldq_store_mask,
           ldq_forward_stq_index, ldq_head, stq_head, stq_address, stq_byte_mask, stq_commit,
           stq_commit_index, flush_ready,
    input  flush_valid, flush_ldq_index, pending_failures, failure_count
  );
  modport slave (
    input  ldq_valid, ldq_succeeded, ldq_forward_stq_data, ldq_address, ldq_byte_mask, ldq_store_mask,
           ldq_forward_stq_index, ldq_head, stq_head, stq_address, stq_byte_mask, stq_commit,
           stq_commit_index, flush_ready,
    output flush_valid, flush_ldq_index, pending_failures, failure_count
  );
endinterface

// File: rtl/order_failure_tracker.sv
// order_failure_tracker: flags succeeded loads made stale by a committing older overlapping store and reports the oldest for flush
//   clk, reset_n (async active-low)
//   bus (slave): load/store queue state and commits in; flush_valid/flush_ldq_index/flush_ready handshake,
//                pending_failures register and saturating failure_count out
//   ORDER_FAILURE_BYTE_MASK_EN: when defined, overlap is same word address plus intersecting byte masks;
//                               otherwise full address equality with byte masks ignored
module order_failure_tracker #(
  parameter int XLEN = 32,
  parameter int LDQ_SIZE = 32,
  parameter int STQ_SIZE = 32,
  parameter int COMMIT_WIDTH = 2
) (
  input logic clk,
  input logic reset_n,
  order_failure_tracker_if.slave bus
);
  localparam int LW = $clog2(LDQ_SIZE);
  localparam int SW = $clog2(STQ_SIZE);
  typedef enum logic {IDLE, REPORT} state_t;
  state_t state;
  logic fv;
  logic [LW-1:0] flush_idx, oldest;
  logic [LDQ_SIZE-1:0] pending, detect, pending_nxt;
  logic [15:0] count;
  logic hs;
`ifndef ORDER_FAILURE_BYTE_MASK_EN
  logic unused_bm;
  assign unused_bm = ^{bus.ldq_byte_mask, bus.stq_byte_mask};
`endif
  assign hs = fv && bus.flush_ready;
  assign bus.flush_valid = fv;
  assign bus.flush_ldq_index = flush_idx;
  assign bus.pending_failures = pending;
  assign bus.failure_count = count;
  // forwarding from a store strictly older than the committing one means the load saw stale data
  always_comb begin
    detect = '0;
    for (int i = 0; i < LDQ_SIZE; i++)
      for (int p = 0; p < COMMIT_WIDTH; p++)
        if (bus.stq_commit[p] && bus.ldq_valid[i] && bus.ldq_succeeded[i]
            && bus.ldq_store_mask[i][bus.stq_commit_index[p]]
`ifdef ORDER_FAILURE_BYTE_MASK_EN
            && bus.ldq_address[i][XLEN-1:2] == bus.stq_address[bus.stq_commit_index[p]][XLEN-1:2]
            && |(bus.ldq_byte_mask[i] & bus.stq_byte_mask[bus.stq_commit_index[p]])
`else
            && bus.ldq_address[i] == bus.stq_address[bus.stq_commit_index[p]]
`endif
            && (!bus.ldq_forward_stq_data[i]
                || SW'(bus.ldq_forward_stq_index[i] - bus.stq_head) < SW'(bus.stq_commit_index[p] - bus.stq_head)))
          detect[i] = 1'b1;
  end
  // a handshake retires the reported load and everything younger; older failures survive
  always_comb begin
    pending_nxt = (pending | detect) & bus.ldq_valid;
    for (int i = 0; i < LDQ_SIZE; i++)
      if (hs && LW'(LW'(i) - bus.ldq_head) >= LW'(flush_idx - bus.ldq_head))
        pending_nxt[i] = 1'b0;
    oldest = '0;
    for (int k = LDQ_SIZE - 1; k >= 0; k--)
      if (pending_nxt[LW'(LW'(k) + bus.ldq_head)])
        oldest = LW'(LW'(k) + bus.ldq_head);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      fv <= 1'b0;
      flush_idx <= '0;
      pending <= '0;
      count <= '0;
    end else begin
      pending <= pending_nxt;
      if (|(pending_nxt & ~pending) && count != 16'hFFFF)
        count <= count + 16'd1;
      if (state == IDLE || hs) begin
        state <= |pending_nxt ? REPORT : IDLE;
        fv <= |pending_nxt;
        if (|pending_nxt)
          flush_idx <= oldest;
      end
    end
  end
endmodule

// File: tb/tb_order_failure_tracker.sv
// tb_order_failure_tracker: directed scenarios plus random traffic checked against a queue-level reference model
module tb_order_failure_tracker;
  localparam int X = 32, L = 32, S = 32, C = 2;
`ifdef ORDER_FAILURE_BYTE_MASK_EN
  localparam bit BM = 1'b1;
`else
  localparam bit BM = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_tests = 0, n_fail = 0;
  bit [L-1:0] m_pend;
  bit m_fv;
  int m_idx, m_cnt;
  order_failure_tracker_if #(.XLEN(X), .LDQ_SIZE(L), .STQ_SIZE(S), .COMMIT_WIDTH(C)) bus ();
  order_failure_tracker #(.XLEN(X), .LDQ_SIZE(L), .STQ_SIZE(S), .COMMIT_WIDTH(C)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bit m_det(int i);
    for (int p = 0; p < C; p++) if (bus.stq_commit[p]) begin
      int s = int'(bus.stq_commit_index[p]);
      int sh = int'(bus.stq_head);
      bit ov;
      if (BM) ov = (bus.ldq_address[i] >> 2) == (bus.stq_address[s] >> 2) && (bus.ldq_byte_mask[i] & bus.stq_byte_mask[s]) != 0;
      else ov = bus.ldq_address[i] == bus.stq_address[s];
      if (bus.ldq_valid[i] && bus.ldq_succeeded[i] && bus.ldq_store_mask[i][s] && ov
          && (!bus.ldq_forward_stq_data[i] || (int'(bus.ldq_forward_stq_index[i]) - sh + S) % S < (s - sh + S) % S))
        return 1'b1;
    end
    return 1'b0;
  endfunction
  function automatic int m_oldest(bit [L-1:0] v, int h);
    for (int k = 0; k < L; k++) if (v[(h + k) % L]) return (h + k) % L;
    return 0;
  endfunction
  // advance model and DUT by one clock, then compare every output
  task automatic step();
    bit [L-1:0] cand;
    bit hs;
    int lh = int'(bus.ldq_head);
    for (int i = 0; i < L; i++) cand[i] = (m_pend[i] | m_det(i)) & bus.ldq_valid[i];
    hs = m_fv && bus.flush_ready;
    if (hs) for (int i = 0; i < L; i++) if ((i - lh + L) % L >= (m_idx - lh + L) % L) cand[i] = 1'b0;
    if ((cand & ~m_pend) != 0 && m_cnt < 65535) m_cnt++;
    if (!m_fv || hs) begin
      m_fv = cand != 0;
      if (cand != 0) m_idx = m_oldest(cand, lh);
    end
    m_pend = cand;
    @(posedge clk);
    #1;
    check("flush_valid", bus.flush_valid, m_fv);
    if (m_fv) check("flush_ldq_index", bus.flush_ldq_index, m_idx);
    check("pending_failures", bus.pending_failures, m_pend);
    check("failure_count", bus.failure_count, m_cnt);
  endtask
  task automatic clear_inputs();
    bus.ldq_valid = '0; bus.ldq_succeeded = '0; bus.ldq_forward_stq_data = '0;
    bus.ldq_address = '0; bus.ldq_byte_mask = '0; bus.ldq_store_mask = '0;
    bus.ldq_forward_stq_index = '0; bus.ldq_head = '0; bus.stq_head = '0;
    bus.stq_address = '0; bus.stq_byte_mask = '0; bus.stq_commit = '0;
    bus.stq_commit_index = '0; bus.flush_ready = 1'b0;
  endtask
  task automatic set_load(int i, logic [31:0] a, int s);
    bus.ldq_valid[i] = 1'b1; bus.ldq_succeeded[i] = 1'b1;
    bus.ldq_address[i] = a; bus.ldq_byte_mask[i] = 4'hF; bus.ldq_store_mask[i][s] = 1'b1;
  endtask
  task automatic set_store(int s, logic [31:0] a);
    bus.stq_address[s] = a; bus.stq_byte_mask[s] = 4'hF;
  endtask
  task automatic commit(int p, int s);
    bus.stq_commit[p] = 1'b1; bus.stq_commit_index[p] = 5'(s);
  endtask
  task automatic drain();
    clear_inputs();
    bus.flush_ready = 1'b1;
    step();
    check("drain_idle", bus.flush_valid, 1'b0);
    clear_inputs();
  endtask
  task automatic rand_cycle();
    logic [31:0] pool [4] = '{32'h100, 32'h104, 32'h106, 32'h200};
    bus.ldq_valid = ($urandom_range(0, 7) == 0) ? $urandom : 32'hFFFF_FFFF;
    bus.ldq_succeeded = $urandom;
    bus.ldq_forward_stq_data = $urandom & $urandom;
    for (int i = 0; i < L; i++) begin
      bus.ldq_address[i] = pool[$urandom_range(0, 3)];
      bus.ldq_byte_mask[i] = 4'($urandom);
      bus.ldq_store_mask[i] = $urandom;
      bus.ldq_forward_stq_index[i] = 5'($urandom);
    end
    for (int s = 0; s < S; s++) begin
      bus.stq_address[s] = pool[$urandom_range(0, 3)];
      bus.stq_byte_mask[s] = 4'($urandom);
    end
    if ($urandom_range(0, 3) == 0) begin
      bus.ldq_head = 5'($urandom);
      bus.stq_head = 5'($urandom);
    end
    bus.stq_commit = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
    for (int p = 0; p < C; p++) bus.stq_commit_index[p] = 5'($urandom);
    bus.flush_ready = $urandom_range(0, 1) == 1;
  endtask
  initial begin
    clear_inputs();
    m_pend = '0; m_fv = 1'b0; m_idx = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flush_valid", bus.flush_valid, 1'b0);
    check("reset_index", bus.flush_ldq_index, 0);
    check("reset_pending", bus.pending_failures, 0);
    check("reset_count", bus.failure_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    // basic failure, reported one cycle after the commit
    set_load(5, 32'h1000, 3); set_store(3, 32'h1000); commit(0, 3);
    step();
    check("basic_fv", bus.flush_valid, 1'b1);
    check("basic_idx", bus.flush_ldq_index, 5);
    check("basic_cnt", bus.failure_count, 1);
    drain();
    // forwarding from a younger store hides the violation, from an older one does not
    bus.stq_head = 5'd2;
    set_load(5, 32'h1000, 3); set_store(3, 32'h1000); commit(0, 3);
    bus.ldq_forward_stq_data[5] = 1'b1; bus.ldq_forward_stq_index[5] = 5'd4;
    step();
    check("fwd_younger_pend", bus.pending_failures, 0);
    bus.ldq_forward_stq_index[5] = 5'd2;
    step();
    check("fwd_older_pend", bus.pending_failures, 32'h20);
    check("fwd_older_fv", bus.flush_valid, 1'b1);
    drain();
    // head wrap: oldest across the wrap is 31, one handshake clears both
    bus.ldq_head = 5'd30;
    set_load(31, 32'h40, 3); set_load(1, 32'h80, 7);
    set_store(3, 32'h40); set_store(7, 32'h80);
    commit(0, 3); commit(1, 7);
    step();
    check("wrap_idx", bus.flush_ldq_index, 31);
    bus.stq_commit = '0; bus.flush_ready = 1'b1;
    step();
    check("wrap_clear_fv", bus.flush_valid, 1'b0);
    check("wrap_clear_pend", bus.pending_failures, 0);
    drain();
    // index held under backpressure while an older load fails
    bus.ldq_head = 5'd28;
    set_load(31, 32'h40, 3); set_load(30, 32'h50, 6);
    set_store(3, 32'h40); set_store(6, 32'h50);
    commit(0, 3);
    step();
    bus.stq_commit = '0; commit(1, 6);
    step();
    bus.stq_commit = '0;
    for (int c = 0; c < 3; c++) step();
    check("hold_idx", bus.flush_ldq_index, 31);
    bus.flush_ready = 1'b1;
    step();
    check("hold_next_fv", bus.flush_valid, 1'b1);
    check("hold_next_idx", bus.flush_ldq_index, 30);
    drain();
    // byte-mask overlap rules
    set_load(5, 32'h104, 3); bus.ldq_byte_mask[5] = 4'b0001;
    set_store(3, 32'h106); bus.stq_byte_mask[3] = 4'b0100;
    commit(0, 3);
    step();
    check("bm_disjoint", bus.pending_failures, 0);
    bus.stq_byte_mask[3] = 4'b0001;
    step();
    check("bm_overlap", bus.pending_failures[5], BM);
    drain();
    // asynchronous reset in the middle of a report
    set_load(9, 32'h10, 1); set_store(1, 32'h10); commit(0, 1);
    step();
    bus.stq_commit = '0;
    reset_n = 1'b0;
    #1;
    check("areset_fv", bus.flush_valid, 1'b0);
    check("areset_pend", bus.pending_failures, 0);
    check("areset_cnt", bus.failure_count, 0);
    m_pend = '0; m_fv = 1'b0; m_idx = 0; m_cnt = 0;
    clear_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rand_cycle();
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
